// File: rtl/ps2_zxkbd_if.sv
// CPU-side port FE bus of the PS/2 ZX keyboard: half-row select in, key bits
// and received-byte status out.
interface ps2_zxkbd_if;
  logic [7:0] address_hi;
  logic [4:0] keys;
  logic [7:0] scancode;
  logic       strobe;

  // CPU / bench side drives the address and observes the keyboard
  modport master (
    output address_hi,
    input  keys,
    input  scancode,
    input  strobe
  );

  // Keyboard side answers the half-row read and reports received bytes
  modport slave (
    input  address_hi,
    output keys,
    output scancode,
    output strobe
  );
endinterface

// File: rtl/ps2_zxkbd.sv
// PS/2 set-2 receiver feeding an 8x5 ZX Spectrum key matrix, read back as
// active-low half-row bits selected by A15..A8 like the ULA's port FE.
module ps2_zxkbd #(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  ps2_zxkbd_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 5;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  typedef logic [ROWS-1:0][COLS-1:0] matrix_t;

  // Synchroniser chains; clk_sync[2] is the extra flop used for edge detect
  logic [2:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             fall;
  logic             dat_s;

  // Receiver state
  state_e           state;
  state_e           cur_state;
  logic [CNT_W-1:0] idle_cnt;
  logic             at_max;
  logic             timeout;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic [7:0]       scancode_q;
  logic             strobe_q;

  // Decoder state
  logic             brk_flag;
  logic             ext_flag;
  matrix_t          matrix;
  matrix_t          mask_c;
  logic [COLS-1:0]  keys_c;

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign at_max  = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign timeout = at_max && (state != S_IDLE);

  // A timeout aborts first; an edge in the same cycle is then handled as if idle
  assign cur_state = timeout ? S_IDLE : state;

  // Two-flop synchronisers, reset to the idle-high line level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Cycles since the last PS/2 falling edge, saturating at the timeout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
    end else if (!at_max) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      scancode_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (fall) begin
        unique case (cur_state)
          S_IDLE: begin
            if (!dat_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
          S_DATA: begin
            shift_reg <= {dat_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(7)) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_bit <= dat_s;
            state   <= S_STOP;
          end
          S_STOP: begin
            if (dat_s && (^{shift_reg, par_bit})) begin
              scancode_q <= shift_reg;
              strobe_q   <= 1'b1;
            end
            state <= S_IDLE;
          end
        endcase
      end else if (timeout) begin
        state <= S_IDLE;
      end
    end
  end

  // Matrix bits touched by one scancode (ext selects the E0-prefixed table)
  function automatic matrix_t key_mask(input logic ext, input logic [7:0] code);
    matrix_t m;
    m = '0;
    if (ext) begin
      if (code == 8'h14) m[7][1] = 1'b1;
    end else begin
      case (code)
        8'h12, 8'h59: m[0][0] = 1'b1;
        8'h1A: m[0][1] = 1'b1;
        8'h22: m[0][2] = 1'b1;
        8'h21: m[0][3] = 1'b1;
        8'h2A: m[0][4] = 1'b1;
        8'h1C: m[1][0] = 1'b1;
        8'h1B: m[1][1] = 1'b1;
        8'h23: m[1][2] = 1'b1;
        8'h2B: m[1][3] = 1'b1;
        8'h34: m[1][4] = 1'b1;
        8'h15: m[2][0] = 1'b1;
        8'h1D: m[2][1] = 1'b1;
        8'h24: m[2][2] = 1'b1;
        8'h2D: m[2][3] = 1'b1;
        8'h2C: m[2][4] = 1'b1;
        8'h16: m[3][0] = 1'b1;
        8'h1E: m[3][1] = 1'b1;
        8'h26: m[3][2] = 1'b1;
        8'h25: m[3][3] = 1'b1;
        8'h2E: m[3][4] = 1'b1;
        8'h45: m[4][0] = 1'b1;
        8'h46: m[4][1] = 1'b1;
        8'h3E: m[4][2] = 1'b1;
        8'h3D: m[4][3] = 1'b1;
        8'h36: m[4][4] = 1'b1;
        8'h4D: m[5][0] = 1'b1;
        8'h44: m[5][1] = 1'b1;
        8'h43: m[5][2] = 1'b1;
        8'h3C: m[5][3] = 1'b1;
        8'h35: m[5][4] = 1'b1;
        8'h5A: m[6][0] = 1'b1;
        8'h4B: m[6][1] = 1'b1;
        8'h42: m[6][2] = 1'b1;
        8'h3B: m[6][3] = 1'b1;
        8'h33: m[6][4] = 1'b1;
        8'h29: m[7][0] = 1'b1;
        8'h14: m[7][1] = 1'b1;
        8'h3A: m[7][2] = 1'b1;
        8'h31: m[7][3] = 1'b1;
        8'h32: m[7][4] = 1'b1;
        // Backspace is typed on a Spectrum as CAPS SHIFT + 0
        8'h66: begin
          m[0][0] = 1'b1;
          m[4][0] = 1'b1;
        end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  assign mask_c = key_mask(ext_flag, scancode_q);

  // Prefix flags and key matrix, updated from each valid received byte
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      brk_flag <= 1'b0;
      ext_flag <= 1'b0;
      matrix   <= '0;
    end else if (strobe_q) begin
      if (scancode_q == 8'hF0) begin
        brk_flag <= 1'b1;
      end else if (scancode_q == 8'hE0) begin
        ext_flag <= 1'b1;
      end else begin
        matrix   <= brk_flag ? (matrix & ~mask_c) : (matrix | mask_c);
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
      end
    end
  end

  // Port FE read: OR of every selected half-row, inverted to active low
  always_comb begin
    logic [COLS-1:0] hit;
    hit = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!bus.address_hi[r]) hit = hit | matrix[r];
    end
    keys_c = ~hit;
  end

  assign bus.keys     = keys_c;
  assign bus.scancode = scancode_q;
  assign bus.strobe   = strobe_q;

endmodule

// File: tb/tb_ps2_zxkbd.sv
// Self-checking bench for ps2_zxkbd: directed cases plus randomized key
// traffic checked against a table-driven model of the keyboard.
module tb_ps2_zxkbd;

  localparam int unsigned TO = 400;  // timeout in clocks, shortened for simulation
  localparam int unsigned H  = 20;   // PS/2 half bit period in clocks

  logic clock;
  logic reset_n;
  logic ps2_clk;
  logic ps2_dat;

  ps2_zxkbd_if bus ();

  ps2_zxkbd #(.TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  int exp_strobes = 0;

  // Model: which keys are held, and the pending prefix flags
  bit         pressed [8][5];
  bit         m_brk;
  bit         m_ext;
  logic [7:0] tbl [8][5];
  logic [7:0] pool [14];

  always @(posedge clock) begin
    if (bus.strobe === 1'b1) strobe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_keys(input logic [7:0] addr);
    logic [4:0] k;
    k = '1;
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 5; b++)
        if (!addr[r] && pressed[r][b]) k[b] = 1'b0;
    return k;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 5; b++)
        pressed[r][b] = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] code);
    if (code == 8'hF0) m_brk = 1'b1;
    else if (code == 8'hE0) m_ext = 1'b1;
    else begin
      if (m_ext) begin
        if (code == 8'h14) pressed[7][1] = !m_brk;
      end else begin
        for (int r = 0; r < 8; r++)
          for (int b = 0; b < 5; b++)
            if (tbl[r][b] == code) pressed[r][b] = !m_brk;
        if (code == 8'h59) pressed[0][0] = !m_brk;
        if (code == 8'h66) begin
          pressed[0][0] = !m_brk;
          pressed[4][0] = !m_brk;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // Shift out the first n bits of an 11-bit frame (start bit first)
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_dat = bits[i];
      repeat (H) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clock);
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit par_flip, input bit stop);
    logic par;
    par = (~^code) ^ par_flip;
    return {stop, par, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code, input bit par_flip, input bit stop);
    send_bits(make_frame(code, par_flip, stop), 11);
    repeat (2 * H) @(negedge clock);
  endtask

  task automatic send_valid(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1);
    model_byte(code);
    exp_strobes++;
  endtask

  task automatic check_keys(input string tag, input logic [7:0] addr);
    bus.address_hi = addr;
    #1;
    check(tag, 32'(bus.keys), 32'(model_keys(addr)));
  endtask

  task automatic check_const(input string tag, input logic [7:0] addr, input logic [4:0] exp);
    bus.address_hi = addr;
    #1;
    check(tag, 32'(bus.keys), 32'(exp));
  endtask

  initial begin
    tbl = '{'{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
            '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
            '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
            '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
            '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
            '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
            '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
            '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}};
    pool = '{8'h1C, 8'h1A, 8'h12, 8'h59, 8'h66, 8'h29, 8'h5A,
             8'h45, 8'h36, 8'h3A, 8'h14, 8'h33, 8'h76, 8'h0D};
    model_clear();

    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    bus.address_hi = 8'hFF;
    repeat (5) @(negedge clock);
    check_const("rst_keys_00", 8'h00, 5'b11111);
    check("rst_scancode", 32'(bus.scancode), 32'h00);
    check("rst_strobe", 32'(bus.strobe), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Single press and release
    send_valid(8'h1C);
    check("press_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check("press_scancode", 32'(bus.scancode), 32'h1C);
    check_const("press_fd", 8'hFD, 5'b11110);
    send_valid(8'hF0);
    send_valid(8'h1C);
    check_const("release_fd", 8'hFD, 5'b11111);

    // Two rows selected at once
    send_valid(8'h1A);
    send_valid(8'h1C);
    check_const("multi_fc", 8'hFC, 5'b11100);
    check_const("multi_fe", 8'hFE, 5'b11101);
    check_const("multi_ff", 8'hFF, 5'b11111);
    send_valid(8'hF0); send_valid(8'h1A);
    send_valid(8'hF0); send_valid(8'h1C);
    check_keys("multi_rel", 8'h00);

    // Extended symbol shift, break prefix after ext prefix
    send_valid(8'hE0); send_valid(8'h14);
    check_const("ext_ss_7f", 8'h7F, 5'b11101);
    send_valid(8'hE0); send_valid(8'hF0); send_valid(8'h14);
    check_const("ext_ss_rel", 8'h7F, 5'b11111);

    // Bad parity and bad stop bit are dropped silently
    send_frame(8'h1C, 1'b1, 1'b1);
    check("badpar_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check_const("badpar_keys", 8'hFD, 5'b11111);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("badstop_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check_const("badstop_keys", 8'hFD, 5'b11111);

    // Partial frame aborted by timeout, next frame received cleanly
    send_bits(make_frame(8'h5A, 1'b0, 1'b1), 5);
    repeat (TO + TO / 10) @(negedge clock);
    send_valid(8'h29);
    check("timeout_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check("timeout_scancode", 32'(bus.scancode), 32'h29);
    check_const("timeout_7f", 8'h7F, 5'b11110);
    send_valid(8'hF0); send_valid(8'h29);

    // Backspace drives CAPS SHIFT and 0 together
    send_valid(8'h66);
    check_const("bksp_fe", 8'hFE, 5'b11110);
    check_const("bksp_ef", 8'hEF, 5'b11110);

    // Reset in the middle of a frame with a break prefix pending
    send_valid(8'hF0);
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 4);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_const("midrst_keys", 8'h00, 5'b11111);
    check("midrst_scancode", 32'(bus.scancode), 32'h00);
    model_clear();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send_valid(8'h1C);
    check("postrst_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check("postrst_scancode", 32'(bus.scancode), 32'h1C);
    check_const("postrst_fd", 8'hFD, 5'b11110);

    // Randomized key traffic against the model
    for (int it = 0; it < 30; it++) begin
      int sel;
      logic [7:0] code;
      sel  = int'($urandom_range(0, 9));
      code = pool[$urandom_range(0, 13)];
      if (sel == 0) begin
        if ($urandom_range(0, 1) == 0) send_frame(code, 1'b1, 1'b1);
        else send_frame(code, 1'b0, 1'b0);
        check("rnd_bad_strobes", 32'(strobe_cnt), 32'(exp_strobes));
      end else begin
        if (sel <= 2) send_valid(8'hE0);
        if ($urandom_range(0, 1) == 0) send_valid(8'hF0);
        send_valid(code);
        check("rnd_strobes", 32'(strobe_cnt), 32'(exp_strobes));
        check("rnd_scancode", 32'(bus.scancode), 32'(code));
      end
      check_keys("rnd_keys_rand", 8'($urandom));
      check_keys("rnd_keys_all", 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_zxkbd.md
# ps2_zxkbd

PS/2 keyboard receiver and ZX Spectrum keyboard-matrix emulator. It sits upstream of the Z80 data path and receives scan-code set 2 frames from the PS2_CLK/PS2_DAT pins. It maintains an 8×5 key matrix and returns the active-low half-row bits that the CPU reads on port FE. It is selected by the upper address byte, in the same way as the Spectrum ULA.

## Interface

Parameters:
- TIMEOUT_CYCLES, 25000: clock cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 25 MHz).

Ports:
- clock  in  1  system clock (clock_25 domain); one clock; all state is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_dat  in  1  raw PS/2 data pin (asynchronous).
- address_hi  in  8  CPU A15..A8 (half-row select, active low).
- keys  out  5  D4..D0 of the port FE read, active low (1 = released).
- scancode  out  8  last valid received byte.
- strobe  out  1  one-cycle pulse per valid received byte.

## Operation

- Synchronisation:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - A falling edge is detected when the third flop of the clock chain is 1 and the synchronised clock is 0.
- Receiver FSM, advanced only on falling edges:
  - IDLE: data=0 → DATA with bit counter=0. Data=1 is a bad start bit: stay in IDLE.
  - DATA: shift data in LSB first. After 8 bits → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP:
    - If stop bit=1 and the parity is odd over data+parity bits, the byte is valid: scancode<=byte and strobe pulses.
    - Otherwise the byte is discarded silently.
    - In either case → IDLE.
- Timeout:
  - An idle counter clears on every falling edge and saturates at TIMEOUT_CYCLES.
  - If it reaches TIMEOUT_CYCLES while the state is not IDLE, the FSM returns to IDLE without a strobe.
- Decoder, acting on each valid byte:
  - F0 sets the break flag. E0 sets the ext flag. Both are order-independent.
  - Any other byte is looked up, then both flags are cleared.
  - Break=1 clears the mapped matrix bits; break=0 sets them.
  - Unmapped codes and ext codes other than E0 14 only clear the flags.
- Matrix (row = address bit, bit = D line):
  - row0 A8: CS(12, 59), Z 1A, X 22, C 21, V 2A
  - row1 A9: A 1C, S 1B, D 23, F 2B, G 34
  - row2 A10: Q 15, W 1D, E 24, R 2D, T 2C
  - row3 A11: 1 16, 2 1E, 3 26, 4 25, 5 2E
  - row4 A12: 0 45, 9 46, 8 3E, 7 3D, 6 36
  - row5 A13: P 4D, O 44, I 43, U 3C, Y 35
  - row6 A14: Enter 5A, L 4B, K 42, J 3B, H 33
  - row7 A15: Space 29, SS(14, E0 14), M 3A, N 31, B 32
  - Backspace 66 maps to CS+0, setting or clearing both keys together.
- Port read:
  - keys[i] = NOT (OR over rows r with address_hi[r]=0 of matrix[r][i]).
  - The read is combinational from address_hi and matrix.
  - address_hi=FF gives 11111.

## Timing

- Reset values:
  - Matrix all released, so keys=11111 for any address_hi.
  - scancode=00, strobe=0, FSM=IDLE, both flags clear, idle counter=0.
- Latencies:
  - A pin falling edge is acted on 3 clocks later.
  - strobe is asserted in the clock after the stop-bit edge is processed.
  - Matrix update is visible on keys one clock after strobe.
- Minimum clock ratio: the PS/2 clock (10–16.7 kHz) is at least 1000× slower than clock, so there are no edge-loss constraints.
- Reset mid-frame: the partial byte and flags are lost. The next frame is received normally.
- The timeout has priority over a falling edge arriving in the same cycle (abort, then the edge is seen in IDLE).
- A byte arriving while the flags are pending simply continues the prefix sequence. There is no flag expiry.

## Test plan

- Valid press:
  - Stimulus: frame 1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1), address_hi=FD.
  - Response: strobe once, scancode=1C, keys=11110.
  - Then send F0,1C. Response: keys=11111.
- Multi-row:
  - Stimulus: press 1A and 1C, address_hi=FC.
  - Response: keys=11100. With address_hi=FE → 11101. With FF → 11111.
- Extended symbol shift:
  - Stimulus: E0,14, address_hi=7F.
  - Response: keys=11101.
  - Then E0,F0,14. Response: 11111.
- Error frames, each giving no strobe and keys unchanged:
  - 1C with parity bit 1.
  - 1C with stop bit 0.
- Timeout:
  - Stimulus: 5 bits, then the clock is held high for 1.1 ms, then a full 29 frame, address_hi=7F.
  - Response: exactly one strobe with scancode=29, keys=11110.
- Backspace and reset:
  - Stimulus: 66.
  - Response: address_hi=FE → 11110, address_hi=EF → 11110.
  - Then assert reset_n low mid-frame. Response: keys=11111 and scancode=00 immediately; the following 1C frame is received correctly.
